// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and exact occupancy tracker for the single-clock FIFO; the handshake takes zero cycles and count is registered.
// Writes are refused while count == DEPTH and reads while count == 0. Define FIFO_ARB_BURST_EN to let a winner keep the port for up to BURST_MAX writes.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_MAX = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_w_en,
  output logic [DATA_W-1:0]       fifo_w_data,
  input  logic                    rd_req,
  output logic                    fifo_r_en,
  output logic [ID_W-1:0]         grant_id,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] rr_idx;
  logic [ID_W-1:0] rr_win;
  logic [ID_W-1:0] win;
  logic            rr_found;
  logic            space;
  logic            grant;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Gating with rst keeps every strobe low while reset is held, not only after the first edge.
  assign space     = rst && (count < DEPTH_C);
  assign fifo_r_en = rst && rd_req && !empty;

  always_comb begin
    rr_found = 1'b0;
    rr_win   = rr_ptr;
    rr_idx   = rr_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int              BC_W      = $clog2(BURST_MAX) + 1;
  localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_MAX);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [BC_W-1:0] burst_cnt, burst_cnt_nxt;
  logic            hold_grant;

  // rr_ptr follows every accepted write, so in HOLD it names the holder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rr_ptr    <= LAST_ID;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (grant) rr_ptr <= win;
    end
  end

  always_comb begin
    state_nxt     = IDLE;
    burst_cnt_nxt = '0;
    if (grant) begin
      state_nxt     = HOLD;
      burst_cnt_nxt = hold_grant ? burst_cnt + BC_W'(1) : BC_W'(1);
    end
  end

  // A lapsed hold falls through to round-robin in the same cycle, so no bubble.
  always_comb begin
    hold_grant = (state == HOLD) && space && req_valid[rr_ptr] && (burst_cnt < BURST_LIM);
    win        = hold_grant ? rr_ptr : rr_win;
    grant      = hold_grant || (space && rr_found);
  end
`else
  assign win   = rr_win;
  assign grant = space && rr_found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rr_ptr <= LAST_ID;
    else if (grant) rr_ptr <= win;
  end

  // BURST_MAX only shapes the burst build.
  if (BURST_MAX < 1) begin : g_burst_cfg
  end
`endif

  always_comb begin
    req_ready   = '0;
    fifo_w_data = '0;
    if (grant) begin
      req_ready[win] = 1'b1;
      fifo_w_data    = req_data[int'(win)*DATA_W +: DATA_W];
    end
  end

  assign fifo_w_en = grant;
  assign grant_id  = grant ? win : last_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_id <= '0;
    else if (grant) last_id <= win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({fifo_w_en, fifo_r_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a queue-based model is checked against the DUT every cycle, and directed scenarios are pinned with literal expectations.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam int BM = 4;
  localparam int CW = $clog2(D) + 1;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_w_data;
  logic              rd_req = 1'b0;
  logic              fifo_r_en;
  logic [IW-1:0]     grant_id;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  always #5 clk = ~clk;

  // Producer i always offers 8'hA0 + i.
  assign req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(D), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data),
    .rd_req(rd_req), .fifo_r_en(fifo_r_en), .grant_id(grant_id),
    .count(count), .full(full), .empty(empty)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: queue of expected FIFO contents, last winner, last reported id.
  logic [7:0] mq[$];
  logic [7:0] dq[$];
  int         gq[$];
  int         last_rr;
  int         last_gid;
  bit         pend, e_w, e_r, found, space;
  int         e_win;
  logic [7:0] m_pop, d_pop;
`ifdef FIFO_ARB_BURST_EN
  bit         hold, e_hg;
  int         bcnt;
`endif

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_rr = N - 1; last_gid = 0; pend = 0;
        mq.delete(); dq.delete(); gq.delete();
`ifdef FIFO_ARB_BURST_EN
        hold = 0; bcnt = 0;
`endif
        chk("rst_ready", req_ready, 0);
        chk("rst_w_en", fifo_w_en, 0);
        chk("rst_w_data", fifo_w_data, 0);
        chk("rst_r_en", fifo_r_en, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
      end else begin
        space = (mq.size() < D);
        found = 0;
        e_win = last_rr;
`ifdef FIFO_ARB_BURST_EN
        e_hg = hold && space && req_valid[last_rr] && (bcnt < BM);
        if (e_hg) found = 1;
`endif
        for (int k = 1; k <= N; k++)
          if (!found && req_valid[(last_rr + k) % N]) begin
            found = 1;
            e_win = (last_rr + k) % N;
          end
        e_w = found && space;
        e_r = rd_req && (mq.size() != 0);
        chk("ready", req_ready, e_w ? (1 << e_win) : 0);
        chk("w_en", fifo_w_en, e_w);
        chk("w_data", fifo_w_data, e_w ? 8'hA0 + e_win : 0);
        chk("r_en", fifo_r_en, e_r);
        chk("gid", grant_id, e_w ? e_win : last_gid);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == D);
        chk("empty", empty, mq.size() == 0);
        if (fifo_w_en) begin
          dq.push_back(fifo_w_data);
          gq.push_back(int'(grant_id));
        end
        pend = 1;
      end
      @(posedge clk);
      if (rst && pend) begin
        if (e_w) begin
          mq.push_back(8'hA0 + 8'(e_win));
          last_rr  = e_win;
          last_gid = e_win;
        end
`ifdef FIFO_ARB_BURST_EN
        if (e_w) begin
          bcnt = e_hg ? bcnt + 1 : 1;
          hold = 1;
        end else begin
          bcnt = 0;
          hold = 0;
        end
`endif
        if (e_r) begin
          m_pop = mq.pop_front();
          d_pop = (dq.size() != 0) ? dq.pop_front() : 8'h00;
          chk("rd_data", d_pop, m_pop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_order[8];

  initial begin : drive
`ifdef FIFO_ARB_BURST_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    tick(); tick();
    #3;
    chk("init_count", count, 0);
    chk("init_empty", empty, 1);
    chk("init_wen", fifo_w_en, 0);
    tick();

    // Fairness after reset release
    rst = 1'b1; req_valid = 4'b1111; rd_req = 1'b0;
    #3;
    chk("first_grant", req_ready, 4'b0001);
    repeat (8) tick();
    chk("fair_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("fair_order", (i < gq.size()) ? gq[i] : -1, exp_order[i]);
      chk("fair_data", (i < dq.size()) ? dq[i] : 8'h00, 8'hA0 + exp_order[i]);
    end

    // Full boundary
    repeat (8) tick();
    #3;
    chk("full_flag", full, 1);
    chk("full_ready", req_ready, 0);
    chk("full_count", count, 16);
    tick();
    rd_req = 1'b1;
    #3;
    chk("full_rd", fifo_r_en, 1);
    chk("full_wr_refused", fifo_w_en, 0);
    tick();
    chk("after_rd_count", count, 15);
    #3;
    chk("next_wr", fifo_w_en, 1);
    tick();
    chk("steady_count", count, 15);

    // Drain, then empty boundary
    req_valid = 4'b0000;
    repeat (15) tick();
    chk("drained", count, 0);
    #3;
    chk("empty_rd_blocked", fifo_r_en, 0);
    tick();
    chk("empty_count", count, 0);
    req_valid = 4'b0001;
    #3;
    chk("empty_wr_rd_blocked", fifo_r_en, 0);
    chk("empty_wr", fifo_w_en, 1);
    tick();
    chk("empty_wr_count", count, 1);

    // Simultaneous traffic at count 5
    req_valid = 4'b0100; rd_req = 1'b0;
    repeat (4) tick();
    chk("fill5", count, 5);
    req_valid = 4'b1111; rd_req = 1'b1;
    repeat (20) tick();
    chk("sim_count", count, 5);

    // Reset mid-traffic
    rd_req = 1'b0;
    tick();
    rst = 1'b0;
    #3;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_wdata", fifo_w_data, 0);
    tick();
    rst = 1'b1;
    #3;
    chk("post_rst_grant", req_ready, 4'b0001);
    chk("post_rst_gid", grant_id, 0);
    tick();

`ifdef FIFO_ARB_BURST_EN
    rst = 1'b0; req_valid = 4'b0011;
    tick();
    rst = 1'b1;
    repeat (9) tick();
    begin
      int bseq[9];
      bseq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 9; i++)
        chk("burst_order", (i < gq.size()) ? gq[i] : -1, bseq[i]);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    req_valid = 4'b0010;
    #3;
    chk("burst_drop", req_ready, 4'b0010);
    tick();
`endif

    req_valid = '0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
